trans_mem: RTL and testbench

- Transfer memory written by the calculator controller's Store state.
- Two instances are used: Trans_Mem1 and Trans_Mem2. Each stores the result words produced from the controller's A/B/Mode outputs, in order.
- The controller drives WEN and CNT_EN. The ALU drives Data_In.
- A separate FIFO-style read port lets results be drained in write order for display or readback.

---
 rtl/trans_mem.sv | 99 +++++++++
 tb/tb_trans_mem.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/trans_mem.sv
// Transfer memory for the calculator controller: stores ALU result words in
// write order and drains them through a FIFO-style registered read port.
module trans_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WEN,
  input  logic              CNT_EN,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Rd_En,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow,
  output logic [ADDR_W-1:0] Wr_Addr
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic pop_acc;
  logic push_acc;
  logic mem_we;

  assign Full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign Empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full memory can still take a push.
  assign pop_acc  = Rd_En && !Empty;
  assign push_acc = CNT_EN && (!Full || pop_acc);
  // A bare WEN rewrites the current slot; a rejected advance writes nothing.
  assign mem_we   = WEN && (push_acc || !CNT_EN);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (CNT_EN && !push_acc) overflow_d  = 1'b1;
    if (Rd_En && Empty)      underflow_d = 1'b1;
  end

  // Control and read-port state; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= pop_acc;
      // Old contents are read here even if the same slot is written this cycle.
      if (pop_acc) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem[wr_ptr_q] <= Data_In;
  end

  assign Rd_Data   = rd_data_q;
  assign Rd_Valid  = rd_valid_q;
  assign Count     = count_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign Wr_Addr   = wr_ptr_q;

endmodule

// File: tb/tb_trans_mem.sv
// Directed self-checking bench for trans_mem.
module tb_trans_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        WEN = 1'b0;
  logic        CNT_EN = 1'b0;
  logic [15:0] Data_In = '0;
  logic        Rd_En = 1'b0;
  logic [15:0] Rd_Data;
  logic        Rd_Valid;
  logic [4:0]  Count;
  logic        Full;
  logic        Empty;
  logic        Overflow;
  logic        Underflow;
  logic [3:0]  Wr_Addr;

  int n_checks = 0;
  int n_fails  = 0;

  trans_mem #(
    .DATA_W (16),
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .WEN       (WEN),
    .CNT_EN    (CNT_EN),
    .Data_In   (Data_In),
    .Rd_En     (Rd_En),
    .Rd_Data   (Rd_Data),
    .Rd_Valid  (Rd_Valid),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Wr_Addr   (Wr_Addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic wen, input logic cnt, input logic rd, input logic [15:0] d);
    WEN = wen; CNT_EN = cnt; Rd_En = rd; Data_In = d;
    @(posedge clock); #1;
    WEN = 1'b0; CNT_EN = 1'b0; Rd_En = 1'b0; Data_In = '0;
  endtask

  // Reset with every other input active, to show reset wins.
  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 16'hDEAD);
    reset = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    step(1'b0, 1'b0, 1'b1, '0);
    check({tag, "_valid"}, 32'(Rd_Valid), 32'd1);
    check({tag, "_data"}, 32'(Rd_Data), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v3 [3];
    v3[0] = 16'h0005; v3[1] = 16'h0100; v3[2] = 16'hFFFF;
    @(negedge clock);

    // Reset state and basic ordered write/read
    do_reset();
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_wr_addr", 32'(Wr_Addr), 32'd0);
    check("rst_rd_valid", 32'(Rd_Valid), 32'd0);
    check("rst_rd_data", 32'(Rd_Data), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_udf", 32'(Underflow), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, v3[i]);
    check("t1_count", 32'(Count), 32'd3);
    check("t1_wr_addr", 32'(Wr_Addr), 32'd3);
    check("t1_empty", 32'(Empty), 32'd0);
    for (int i = 0; i < 3; i++) pop_check($sformatf("t1_pop%0d", i), v3[i]);
    step(1'b0, 1'b0, 1'b0, '0);
    check("t1_valid_drop", 32'(Rd_Valid), 32'd0);
    check("t1_data_hold", 32'(Rd_Data), 32'hFFFF);
    check("t1_empty_end", 32'(Empty), 32'd1);

    // Fill, overflow, drain
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
    check("t2_full", 32'(Full), 32'd1);
    check("t2_count16", 32'(Count), 32'd16);
    step(1'b1, 1'b1, 1'b0, 16'hAAAA);
    check("t2_ovf", 32'(Overflow), 32'd1);
    check("t2_count_hold", 32'(Count), 32'd16);
    check("t2_wr_addr", 32'(Wr_Addr), 32'd0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t2_pop%0d", i), 16'(i));
    check("t2_empty", 32'(Empty), 32'd1);

    // Full with simultaneous push and pop: read-before-write
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    check("t3_rd_data", 32'(Rd_Data), 32'd0);
    check("t3_rd_valid", 32'(Rd_Valid), 32'd1);
    check("t3_count", 32'(Count), 32'd16);
    check("t3_no_ovf", 32'(Overflow), 32'd0);
    // 16 entries remain: 1..15 then the new word in slot 0.
    for (int i = 1; i < 16; i++) pop_check($sformatf("t3_pop%0d", i), 16'(i));
    pop_check("t3_last", 16'h1234);
    check("t3_empty", 32'(Empty), 32'd1);

    // Write without advance is overwritten by the next write
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0011);
    check("t4_count0", 32'(Count), 32'd0);
    check("t4_wr_addr0", 32'(Wr_Addr), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0022);
    check("t4_count1", 32'(Count), 32'd1);
    pop_check("t4_pop", 16'h0022);

    // Underflow, and push plus pop while empty
    do_reset();
    step(1'b0, 1'b0, 1'b1, '0);
    check("t5_valid0", 32'(Rd_Valid), 32'd0);
    check("t5_udf", 32'(Underflow), 32'd1);
    check("t5_count0", 32'(Count), 32'd0);
    step(1'b1, 1'b1, 1'b1, 16'h0007);
    check("t5_count1", 32'(Count), 32'd1);
    check("t5_valid_still0", 32'(Rd_Valid), 32'd0);
    pop_check("t5_pop", 16'h0007);
    check("t5_udf_sticky", 32'(Underflow), 32'd1);

    // Reset mid-sequence discards pending state
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h0100 + i));
    check("t6_count5", 32'(Count), 32'd5);
    pop_check("t6_pop", 16'h0100);
    do_reset();
    check("t6_count", 32'(Count), 32'd0);
    check("t6_empty", 32'(Empty), 32'd1);
    check("t6_ovf", 32'(Overflow), 32'd0);
    check("t6_udf", 32'(Underflow), 32'd0);
    check("t6_valid", 32'(Rd_Valid), 32'd0);
    check("t6_wr_addr", 32'(Wr_Addr), 32'd0);
    check("t6_rd_data", 32'(Rd_Data), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0055);
    check("t6_wr_addr1", 32'(Wr_Addr), 32'd1);
    check("t6_count1", 32'(Count), 32'd1);
    pop_check("t6_pop_after", 16'h0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
